a2d_round_robin: RTL and testbench

Upstream sequencer feeding the rider-detect / steering-enable stage. On each `nxt` request it walks four A2D channels (left load cell, right load cell, steer pot, battery) over a shared 16-bit SPI master. Each channel takes two SPI transactions: one issues the channel command, the next returns the 12-bit result. It holds the latest results in registers that drive `lft_ld`, `rght_ld`, `steer_pot` and `batt` to downstream logic.

---
 rtl/a2d_round_robin.sv | 194 +++++++++++++++++++
 tb/tb_a2d_round_robin.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_round_robin.sv
// a2d_round_robin: sequences four A2D channels (left load cell, right load
// cell, steer pot, battery) over a shared 16-bit SPI master on each `nxt`
// request. Each channel uses a command transaction followed by a read
// transaction. The latest results are held in registers.
//
// Optional feature macro: A2D_LD_AVG_EN
//   defined   -> lft_ld / rght_ld hold a 2-tap running average (the first
//                capture after reset loads raw); steer_pot / batt stay raw.
//   undefined -> all four channels load the raw 12-bit sample.
//
// Handshake: spi_wrt is a one-clock start pulse. spi_cmd is stable from the
// spi_wrt cycle until the matching spi_done. spi_done is a one-clock
// completion pulse, and spi_rd_data is valid only in that cycle. spi_done is
// only honoured in WCMD and WRD.
module a2d_round_robin #(
  parameter int GAP_CYC  = 2,
  parameter int CH_LFT   = 0,
  parameter int CH_RGHT  = 4,
  parameter int CH_STEER = 5,
  parameter int CH_BATT  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  input  logic        spi_done,
  input  logic [15:0] spi_rd_data,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        round_vld,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CMD  = 3'd1;
  localparam logic [2:0] WCMD = 3'd2;
  localparam logic [2:0] GAP  = 3'd3;
  localparam logic [2:0] RD   = 3'd4;
  localparam logic [2:0] WRD  = 3'd5;

  localparam logic [3:0] GAP_LD = 4'(GAP_CYC);
  localparam logic [2:0] CH0    = 3'(CH_LFT);
  localparam logic [2:0] CH1    = 3'(CH_RGHT);
  localparam logic [2:0] CH2    = 3'(CH_STEER);
  localparam logic [2:0] CH3    = 3'(CH_BATT);

  logic [2:0]  state;
  logic [1:0]  idx;
  logic [3:0]  gap_cnt;
  logic        capture;
  logic [11:0] sample;

  // Command word for a given channel slot: {2'b00, ch[2:0], 11'h000}.
  function automatic logic [15:0] cmd_word(input logic [1:0] i);
    logic [2:0] ch;
    case (i)
      2'd0:    ch = CH0;
      2'd1:    ch = CH1;
      2'd2:    ch = CH2;
      default: ch = CH3;
    endcase
    return {2'b00, ch, 11'h000};
  endfunction

  assign capture   = (state == WRD) && spi_done;
  assign sample    = spi_rd_data[11:0];
  assign spi_wrt   = (state == CMD) || (state == RD);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Main sequencer: state, channel index, gap counter and transmit word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= 2'd0;
      gap_cnt <= 4'd0;
      spi_cmd <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (nxt) begin
            state   <= CMD;
            spi_cmd <= cmd_word(idx);
          end
        end
        CMD: state <= WCMD;
        WCMD: begin
          if (spi_done) begin
            gap_cnt <= GAP_LD;
            state   <= GAP;
          end
        end
        GAP: begin
          // Counter is loaded with GAP_CYC >= 1; leaving on the 1->0 step
          // gives exactly GAP_CYC idle clocks in this state.
          if (gap_cnt <= 4'd1) begin
            gap_cnt <= 4'd0;
            spi_cmd <= 16'h0000;
            state   <= RD;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        RD: state <= WRD;
        WRD: begin
          if (spi_done) begin
            if (idx == 2'd3) begin
              idx   <= 2'd0;
              state <= IDLE;
            end else begin
              idx     <= idx + 2'd1;
              spi_cmd <= cmd_word(idx + 2'd1);
              state   <= CMD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Round-complete pulse: high the cycle after the BATT capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_vld <= 1'b0;
    end else begin
      round_vld <= capture && (idx == 2'd3);
    end
  end

`ifdef A2D_LD_AVG_EN
  logic        seen_lft;
  logic        seen_rght;
  logic [12:0] lft_sum;
  logic [12:0] rght_sum;
  logic        unused_bits;

  assign lft_sum     = {1'b0, lft_ld} + {1'b0, sample};
  assign rght_sum    = {1'b0, rght_ld} + {1'b0, sample};
  assign unused_bits = ^{spi_rd_data[15:12], lft_sum[0], rght_sum[0]};

  // Result registers: load-cell channels average with the previous value
  // once a first sample has been seen; steer and battery load raw.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lft_ld    <= 12'h000;
      rght_ld   <= 12'h000;
      steer_pot <= 12'h000;
      batt      <= 12'h000;
      seen_lft  <= 1'b0;
      seen_rght <= 1'b0;
    end else if (capture) begin
      case (idx)
        2'd0: begin
          lft_ld   <= seen_lft ? lft_sum[12:1] : sample;
          seen_lft <= 1'b1;
        end
        2'd1: begin
          rght_ld   <= seen_rght ? rght_sum[12:1] : sample;
          seen_rght <= 1'b1;
        end
        2'd2:    steer_pot <= sample;
        default: batt      <= sample;
      endcase
    end
  end
`else
  logic unused_bits;

  assign unused_bits = ^spi_rd_data[15:12];

  // Result registers: every channel loads the raw sample on its capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lft_ld    <= 12'h000;
      rght_ld   <= 12'h000;
      steer_pot <= 12'h000;
      batt      <= 12'h000;
    end else if (capture) begin
      case (idx)
        2'd0:    lft_ld    <= sample;
        2'd1:    rght_ld   <= sample;
        2'd2:    steer_pot <= sample;
        default: batt      <= sample;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_a2d_round_robin.sv
// Testbench for a2d_round_robin: an SPI master model with fixed latency
// answers the DUT's transactions, while a channel-level reference model
// predicts command words, spacing, latency and result register contents.
`timescale 1ns/1ps
module tb_a2d_round_robin;

  localparam int GAP = 2;
  localparam int T   = 16;
  localparam int ROUND_LAT = 4 * (1 + T + GAP + 1 + T) + 1;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nxt = 1'b0;
  logic        spi_done = 1'b0;
  logic [15:0] spi_rd_data = 16'h0000;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic        round_vld, busy;
  logic [2:0]  dbg_state;

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  a2d_round_robin #(.GAP_CYC(GAP)) dut (
    .clk(clk), .rst(rst), .nxt(nxt), .spi_done(spi_done),
    .spi_rd_data(spi_rd_data), .spi_wrt(spi_wrt), .spi_cmd(spi_cmd),
    .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
    .round_vld(round_vld), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int total = 0;
  int bad   = 0;
  int vld_cnt = 0;
  int exp_reg [4];
  bit seen [4];
  logic [15:0] rd_data [4];
  bit hold_nxt  = 1'b0;
  bit noise_nxt = 1'b0;

  always @(negedge clk) if (round_vld) vld_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int ch_of(input int i);
    case (i)
      0: return 0;
      1: return 4;
      2: return 5;
      default: return 6;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      exp_reg[i] = 0;
      seen[i] = 1'b0;
    end
  endtask

  task automatic model_capture(input int i, input int s);
`ifdef A2D_LD_AVG_EN
    if (i < 2 && seen[i]) exp_reg[i] = (exp_reg[i] + s) / 2;
    else exp_reg[i] = s;
`else
    exp_reg[i] = s;
`endif
    seen[i] = 1'b1;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_lft"},   lft_ld,    exp_reg[0]);
    chk({tag, "_rght"},  rght_ld,   exp_reg[1]);
    chk({tag, "_steer"}, steer_pot, exp_reg[2]);
    chk({tag, "_batt"},  batt,      exp_reg[3]);
  endtask

  // ---------------- driver tasks ----------------
  // Advance to the next falling edge; clears any spi_done pulse and drives nxt.
  task automatic step();
    @(negedge clk);
    spi_done = 1'b0;
    nxt = noise_nxt ? 1'($urandom_range(0, 1)) : hold_nxt;
  endtask

  task automatic wait_wrt(output logic [15:0] c, output int t);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!spi_wrt && n < 400);
    chk("wrt_seen", spi_wrt, 1'b1);
    c = spi_cmd;
    t = cyc;
  endtask

  // Called at the spi_wrt falling edge; completes the transaction T clocks later.
  task automatic give_done(input logic [15:0] d, output int td);
    repeat (T) step();
    spi_done = 1'b1;
    spi_rd_data = d;
    td = cyc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nxt = 1'b0;
    spi_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One full round; entered on a falling edge where nxt is (re)asserted.
  task automatic run_round(input bit inj);
    int t0, tw, td, exp_t;
    logic [15:0] c;
    t0 = cyc;
    nxt = 1'b1;
    exp_t = t0 + 1;
    for (int i = 0; i < 4; i++) begin
      wait_wrt(c, tw);
      chk("cmd_time", tw, exp_t);
      chk("cmd_word", c, ch_of(i) * 2048);
      give_done(16'($urandom), td);
      if (inj) begin
        step();
        spi_done = 1'b1;
        spi_rd_data = 16'hDEAD;
      end
      wait_wrt(c, tw);
      chk("gap_time", tw, td + GAP + 1);
      chk("rd_word", c, 0);
      give_done(rd_data[i], td);
      model_capture(i, int'(rd_data[i][11:0]));
      exp_t = td + 1;
    end
    step();
    nxt = hold_nxt;
    chk("round_vld", round_vld, 1'b1);
    chk("busy_end", busy, 1'b0);
    chk("latency", cyc - t0, ROUND_LAT);
    chk_regs("round");
  endtask

  task automatic rand_data();
    for (int i = 0; i < 4; i++) rd_data[i] = 16'($urandom);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int v0, tw, td;
    logic [15:0] c;

    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wrt", spi_wrt, 1'b0);
    chk("rst_cmd", spi_cmd, 16'h0000);
    chk("rst_vld", round_vld, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk_regs("rst");

    // Directed round with the reference data set
    rd_data[0] = 16'hF123; rd_data[1] = 16'h0456;
    rd_data[2] = 16'h0789; rd_data[3] = 16'h0ABC;
    v0 = vld_cnt;
    run_round(1'b0);
    chk("dir_lft", lft_ld, 12'h123);
    chk("dir_batt", batt, 12'hABC);
    step();
    chk("vld_clear", round_vld, 1'b0);
    chk("dir_vld_cnt", vld_cnt - v0, 1);

    // nxt noise during the round plus spi_done injected in GAP
    noise_nxt = 1'b1;
    rand_data();
    v0 = vld_cnt;
    run_round(1'b1);
    noise_nxt = 1'b0;
    repeat (3) step();
    chk("noise_vld_cnt", vld_cnt - v0, 1);
    chk("noise_idle", busy, 1'b0);

    // Reset during WRD of the RGHT channel
    do_reset();
    @(negedge clk);
    rd_data[0] = 16'h0123;
    nxt = 1'b1;
    wait_wrt(c, tw);
    give_done(16'h0000, td);
    wait_wrt(c, tw);
    give_done(rd_data[0], td);
    model_capture(0, 12'h123);
    wait_wrt(c, tw);
    chk("mid_cmd_rght", c, 16'h2000);
    give_done(16'h0000, td);
    wait_wrt(c, tw);
    repeat (5) step();
    chk("mid_lft_pre", lft_ld, 12'h123);
    chk("mid_busy_pre", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_lft", lft_ld, 12'h000);
    chk("arst_busy", busy, 1'b0);
    chk("arst_wrt", spi_wrt, 1'b0);
    chk("arst_cmd", spi_cmd, 16'h0000);
    chk("arst_vld", round_vld, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    spi_done = 1'b1;
    spi_rd_data = 16'h0FFF;
    v0 = vld_cnt;
    repeat (4) step();
    chk("late_done_busy", busy, 1'b0);
    chk("late_done_wrt", spi_wrt, 1'b0);
    chk_regs("late_done");
    chk("late_done_vld", vld_cnt - v0, 0);
    rand_data();
    run_round(1'b0);

    // Load-cell averaging (raw when the feature is not built)
    do_reset();
    @(negedge clk);
    rand_data();
    rd_data[0] = 16'h0100;
    run_round(1'b0);
`ifdef A2D_LD_AVG_EN
    chk("avg_r1", lft_ld, 12'h100);
`endif
    step();
    rand_data();
    rd_data[0] = 16'h0201;
    run_round(1'b0);
`ifdef A2D_LD_AVG_EN
    chk("avg_r2", lft_ld, 12'h180);
`endif
    chk("avg_batt_raw", batt, rd_data[3][11:0]);

    // Back-to-back rounds with nxt held high
    step();
    hold_nxt = 1'b1;
    v0 = vld_cnt;
    for (int r = 0; r < 3; r++) begin
      if (r == 2) hold_nxt = 1'b0;
      rand_data();
      run_round(1'b0);
    end
    repeat (2) step();
    chk("b2b_vld_cnt", vld_cnt - v0, 3);
    chk("b2b_idle", busy, 1'b0);

    // A few more random rounds with random idle spacing
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(1, 6)) step();
      rand_data();
      run_round(1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #3000000;
    $display("FAIL timeout reached at cyc %0d", cyc);
    $fatal(1);
  end

endmodule
